// File: rtl/safe_startup_controller.sv
// Pump start-up supervisor: sequences pump enable, pressure confirmation and
// master start permit, latching faults until an operator clear with start released.
module safe_startup_controller #(
  parameter int PUMP_TIMEOUT   = 16,
  parameter int PRESS_TIMEOUT  = 32,
  parameter int PRESS_DEBOUNCE = 4,
  parameter int CNT_W          = 8
) (
  input  logic       System_Clk,
  input  logic       System_Reset_n,
  input  logic       Start_Request,
  input  logic       Stop_Request,
  input  logic       Pump_ON_Signal,
  input  logic       Pressure_OK_Signal,
  input  logic       Fault_Clear,
  output logic       Pump_Enable,
  output logic       Master_Start,
  output logic       Fault_Latched,
  output logic [1:0] Fault_Code,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'b000,
    ST_PUMP_START = 3'b001,
    ST_PRESS_WAIT = 3'b010,
    ST_RUN        = 3'b011,
    ST_FAULT      = 3'b100
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_NO_START = 2'b01;
  localparam logic [1:0] FC_PRESS_TO = 2'b10;
  localparam logic [1:0] FC_LOSS     = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PUMP_LAST  = CNT_W'(PUMP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DEB_FULL   = CNT_W'(PRESS_DEBOUNCE);

  logic             r_rst_meta;
  logic             r_rst_sync;
  logic             w_rst_n;
  logic             r_pump_meta;
  logic             r_pump_s;
  logic             r_press_meta;
  logic             r_press_s;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_timer;
  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_fault_code;
  logic [1:0]       w_next_code;
  logic             w_press_stable;
  logic             w_pump_timeout;
  logic             w_press_timeout;
  logic             r_pump_en;
  logic             r_master;
  logic             r_fault;

  // Reset assertion is immediate; release is retimed to the clock.
  always_ff @(posedge System_Clk or negedge System_Reset_n) begin
    if (!System_Reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // Two-flop synchronizers for the asynchronous plant feedback.
  always_ff @(posedge System_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pump_meta  <= 1'b0;
      r_pump_s     <= 1'b0;
      r_press_meta <= 1'b0;
      r_press_s    <= 1'b0;
    end else begin
      r_pump_meta  <= Pump_ON_Signal;
      r_pump_s     <= r_pump_meta;
      r_press_meta <= Pressure_OK_Signal;
      r_press_s    <= r_press_meta;
    end
  end

  // Pressure debounce: counts consecutive synced-high cycles, saturating.
  always_ff @(posedge System_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_deb_cnt <= CNT_ZERO;
    end else if (!r_press_s) begin
      r_deb_cnt <= CNT_ZERO;
    end else if (r_deb_cnt != DEB_FULL) begin
      r_deb_cnt <= r_deb_cnt + CNT_ONE;
    end else begin
      r_deb_cnt <= r_deb_cnt;
    end
  end

  assign w_press_stable = (r_deb_cnt == DEB_FULL);

  // State dwell timer, restarted on every state change.
  always_ff @(posedge System_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_timer <= CNT_ZERO;
    end else if (w_next_state != r_state) begin
      r_timer <= CNT_ZERO;
    end else if (r_timer != CNT_MAX) begin
      r_timer <= r_timer + CNT_ONE;
    end else begin
      r_timer <= r_timer;
    end
  end

  assign w_pump_timeout  = (r_timer == PUMP_LAST) && !r_pump_s;
  assign w_press_timeout = (r_timer == PRESS_LAST) && !(w_press_stable && r_pump_s);

  // State register.
  always_ff @(posedge System_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and fault code; fault detection outranks stop, stop outranks progress.
  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_fault_code;
    case (r_state)
      ST_IDLE: begin
        if (Start_Request && !Stop_Request) begin
          w_next_state = ST_PUMP_START;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_PUMP_START: begin
        if (w_pump_timeout) begin
          w_next_state = ST_FAULT;
          w_next_code  = FC_NO_START;
        end else if (Stop_Request) begin
          w_next_state = ST_IDLE;
        end else if (r_pump_s) begin
          w_next_state = ST_PRESS_WAIT;
        end else begin
          w_next_state = ST_PUMP_START;
        end
      end
      ST_PRESS_WAIT: begin
        if (!r_pump_s) begin
          w_next_state = ST_FAULT;
          w_next_code  = FC_LOSS;
        end else if (w_press_timeout) begin
          w_next_state = ST_FAULT;
          w_next_code  = FC_PRESS_TO;
        end else if (Stop_Request) begin
          w_next_state = ST_IDLE;
        end else if (w_press_stable) begin
          w_next_state = ST_RUN;
        end else begin
          w_next_state = ST_PRESS_WAIT;
        end
      end
      ST_RUN: begin
        if (!r_pump_s || !r_press_s) begin
          w_next_state = ST_FAULT;
          w_next_code  = FC_LOSS;
        end else if (Stop_Request) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (Fault_Clear && !Start_Request) begin
          w_next_state = ST_IDLE;
          w_next_code  = FC_NONE;
        end else begin
          w_next_state = ST_FAULT;
        end
      end
      default: begin
        w_next_state = ST_FAULT;
        w_next_code  = FC_LOSS;
      end
    endcase
  end

  // Outputs decoded from the next state so they move on the same edge as State.
  always_ff @(posedge System_Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pump_en    <= 1'b0;
      r_master     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
    end else begin
      r_pump_en    <= (w_next_state == ST_PUMP_START) ||
                      (w_next_state == ST_PRESS_WAIT) ||
                      (w_next_state == ST_RUN);
      r_master     <= (w_next_state == ST_RUN);
      r_fault      <= (w_next_state == ST_FAULT);
      r_fault_code <= w_next_code;
    end
  end

  assign Pump_Enable   = r_pump_en;
  assign Master_Start  = r_master;
  assign Fault_Latched = r_fault;
  assign Fault_Code    = r_fault_code;
  assign State         = r_state;

endmodule

// File: tb/tb_safe_startup_controller.sv
// Scoreboard bench: stimulus queues expected output transitions with their edge
// number; a negedge monitor pops and compares whenever the outputs change.
module tb_safe_startup_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       pump;
  logic       press;
  logic       fclr;
  logic       pump_en;
  logic       master;
  logic       fault;
  logic [1:0] code;
  logic [2:0] state;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       pe;
    logic       ms;
    logic       fl;
    logic [1:0] code;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev;
  int         c;

  safe_startup_controller dut (
    .System_Clk         (clk),
    .System_Reset_n     (rst_n),
    .Start_Request      (start),
    .Stop_Request       (stop),
    .Pump_ON_Signal     (pump),
    .Pressure_OK_Signal (press),
    .Fault_Clear        (fclr),
    .Pump_Enable        (pump_en),
    .Master_Start       (master),
    .Fault_Latched      (fault),
    .Fault_Code         (code),
    .State              (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output change must match the next queued expectation.
  always @(negedge clk) begin
    logic [7:0] cur;
    exp_t       e;
    cur = {state, pump_en, master, fault, code};
    if (mon_en && (cur !== prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change: got st=%b pe=%b ms=%b fl=%b code=%b at edge %0d, required no change",
                 state, pump_en, master, fault, code, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((cur !== {e.st, e.pe, e.ms, e.fl, e.code}) || (cyc != e.at)) begin
          failures++;
          $display("FAIL %s: got st=%b pe=%b ms=%b fl=%b code=%b at edge %0d, required st=%b pe=%b ms=%b fl=%b code=%b at edge %0d",
                   e.tag, state, pump_en, master, fault, code, cyc,
                   e.st, e.pe, e.ms, e.fl, e.code, e.at);
        end
      end
      prev = cur;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [2:0] st, input logic [1:0] fc, input int at);
    exp_t e;
    e.tag  = tag;
    e.st   = st;
    e.pe   = (st == 3'b001) || (st == 3'b010) || (st == 3'b011);
    e.ms   = (st == 3'b011);
    e.fl   = (st == 3'b100);
    e.code = fc;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 80)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d expected transitions still pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    step(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    pump  = 1'b0;
    press = 1'b0;
    fclr  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, pump_en, master, fault, code} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: got st=%b pe=%b ms=%b fl=%b code=%b, required all zero",
               state, pump_en, master, fault, code);
    end
    step(3);
    rst_n = 1'b1;
    step(4);
    prev   = {state, pump_en, master, fault, code};
    mon_en = 1'b1;

    // Nominal sequence.
    start = 1'b1;
    push("nom_pump_start", 3'b001, 2'b00, cyc + 1);
    step(1);
    start = 1'b0;
    step(2);
    pump = 1'b1;
    push("nom_press_wait", 3'b010, 2'b00, cyc + 3);
    step(2);
    press = 1'b1;
    push("nom_run", 3'b011, 2'b00, cyc + 7);
    drain("nominal");

    // Stop while running.
    stop = 1'b1;
    push("stop_in_run", 3'b000, 2'b00, cyc + 1);
    step(1);
    stop  = 1'b0;
    pump  = 1'b0;
    press = 1'b0;
    drain("stop_run");

    // Pump never starts.
    start = 1'b1;
    push("nostart_pump_start", 3'b001, 2'b00, cyc + 1);
    push("nostart_fault", 3'b100, 2'b01, cyc + 17);
    step(1);
    start = 1'b0;
    drain("no_start");

    // Clear with start held must not leave FAULT.
    start = 1'b1;
    fclr  = 1'b1;
    step(6);
    checks++;
    if (state !== 3'b100 || code !== 2'b01) begin
      failures++;
      $display("FAIL clear_with_start: got st=%b code=%b, required st=100 code=01", state, code);
    end
    start = 1'b0;
    push("clear_to_idle", 3'b000, 2'b00, cyc + 1);
    step(1);
    fclr = 1'b0;
    drain("clear");

    // Stop coincident with the pump timeout cycle.
    c = cyc;
    start = 1'b1;
    push("prio_pump_start", 3'b001, 2'b00, c + 1);
    push("prio_fault", 3'b100, 2'b01, c + 17);
    step(1);
    start = 1'b0;
    step(15);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    drain("priority");
    fclr = 1'b1;
    push("prio_clear", 3'b000, 2'b00, cyc + 1);
    step(1);
    fclr = 1'b0;
    drain("prio_clear");

    // Pressure chatter never debounces; times out in PRESS_WAIT.
    c = cyc;
    start = 1'b1;
    pump  = 1'b1;
    push("chat_pump_start", 3'b001, 2'b00, c + 1);
    push("chat_press_wait", 3'b010, 2'b00, c + 3);
    push("chat_fault", 3'b100, 2'b10, c + 35);
    step(1);
    start = 1'b0;
    step(2);
    for (int i = 0; i < 10; i++) begin
      press = 1'b1;
      step(2);
      press = 1'b0;
      step(2);
    end
    drain("chatter");
    pump = 1'b0;
    fclr = 1'b1;
    push("chat_clear", 3'b000, 2'b00, cyc + 1);
    step(1);
    fclr = 1'b0;
    drain("chat_clear");

    // Single-cycle pressure loss while running.
    c = cyc;
    start = 1'b1;
    pump  = 1'b1;
    press = 1'b1;
    push("loss_pump_start", 3'b001, 2'b00, c + 1);
    push("loss_press_wait", 3'b010, 2'b00, c + 3);
    push("loss_run", 3'b011, 2'b00, c + 7);
    step(1);
    start = 1'b0;
    step(9);
    press = 1'b0;
    push("loss_fault", 3'b100, 2'b11, cyc + 3);
    step(1);
    press = 1'b1;
    drain("loss");
    press = 1'b0;
    pump  = 1'b0;
    fclr  = 1'b1;
    push("loss_clear", 3'b000, 2'b00, cyc + 1);
    step(1);
    fclr = 1'b0;
    drain("loss_clear");

    // Reset asserted mid PRESS_WAIT.
    c = cyc;
    start = 1'b1;
    pump  = 1'b1;
    push("rst_pump_start", 3'b001, 2'b00, c + 1);
    push("rst_press_wait", 3'b010, 2'b00, c + 3);
    step(1);
    start = 1'b0;
    step(4);
    push("rst_idle", 3'b000, 2'b00, cyc + 1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, pump_en, master, fault} !== 6'b000000) begin
      failures++;
      $display("FAIL async_reset: got st=%b pe=%b ms=%b fl=%b, required all zero before a clock edge",
               state, pump_en, master, fault);
    end
    pump = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(6);
    drain("reset_mid");

    // Sequence restarts normally after reset release.
    start = 1'b1;
    push("post_rst_start", 3'b001, 2'b00, cyc + 1);
    step(1);
    start = 1'b0;
    stop  = 1'b1;
    push("post_rst_stop", 3'b000, 2'b00, cyc + 1);
    step(1);
    stop = 1'b0;
    drain("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
